// File: rtl/sdram_device_model.sv
// rtl/sdram_device_model.sv - cycle-accurate SDRAM command-bus responder
//
// Purpose:
//   Sits on the pins of the SDRAM controller and behaves like the device:
//   decodes CS/RAS/CAS/WE commands, tracks the open row per bank, stores
//   WRITE data in an internal word array and returns READ data on dq_out
//   CAS_LAT cycles after the READ was sampled. Only the low MEM_ROW_BITS of
//   the row address index the array, so higher rows alias onto lower ones.
//
// Optional feature:
//   SDRAM_MODEL_CHECK_EN - when defined, per-bank timing counters and a
//   protocol checker drive the sticky err output; otherwise err is tied 0.
//
// Ports:
//   clk        in   1   sole clock, all inputs sampled on the rising edge
//   rst        in   1   synchronous active-high reset
//   sdram_cle  in   1   clock enable, 0 suppresses command decode
//   sdram_cs   in   1   chip select, active low
//   sdram_ras  in   1   row strobe, active low
//   sdram_cas  in   1   column strobe, active low
//   sdram_we   in   1   write enable, active low
//   sdram_dqm  in   1   write mask, 1 discards WRITE data
//   sdram_ba   in   2   bank address
//   sdram_a    in   13  row (ACTIVE), column in a[9:2] (READ/WRITE),
//                       a[10] = all banks (PRECHARGE), mode (LMR)
//   dq_in      in   32  write data, valid in the WRITE cycle
//   dq_out     out  32  read data, holds its last value between reads
//   row_open   out  4   per-bank open flag
//   ref_cnt    out  16  REFRESH commands seen, saturating
//   err        out  1   sticky protocol-violation flag

module sdram_device_model #(
  parameter int CAS_LAT      = 2,
  parameter int MEM_ROW_BITS = 4,
  parameter int T_RCD        = 3,
  parameter int T_RP         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cle,
  input  logic        sdram_cs,
  input  logic        sdram_ras,
  input  logic        sdram_cas,
  input  logic        sdram_we,
  input  logic        sdram_dqm,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic [31:0] dq_in,
  output logic [31:0] dq_out,
  output logic [3:0]  row_open,
  output logic [15:0] ref_cnt,
  output logic        err
);

  localparam int IDX_BITS = 2 + MEM_ROW_BITS + 8;
  localparam int DEPTH    = 1 << IDX_BITS;

  typedef enum logic [2:0] {
    CMD_LMR       = 3'b000,
    CMD_REFRESH   = 3'b001,
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVE    = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101,
    CMD_TERMINATE = 3'b110,
    CMD_NOP       = 3'b111
  } cmd_t;

  // ------------------------------------------------------------------
  // Command decode: deselect or clock-enable low both look like NOP.
  // ------------------------------------------------------------------
  cmd_t cmd;

  always_comb begin
    cmd = CMD_NOP;
    if (sdram_cle && !sdram_cs) begin
      cmd = cmd_t'({sdram_ras, sdram_cas, sdram_we});
    end
  end

  logic is_act;
  logic is_rd;
  logic is_wr;
  logic is_pre;
  logic is_ref;
  logic is_lmr;

  assign is_act = (cmd == CMD_ACTIVE);
  assign is_rd  = (cmd == CMD_READ);
  assign is_wr  = (cmd == CMD_WRITE);
  assign is_pre = (cmd == CMD_PRECHARGE);
  assign is_ref = (cmd == CMD_REFRESH);
  assign is_lmr = (cmd == CMD_LMR);

  // ------------------------------------------------------------------
  // Row state and mode register.
  // Only the row bits that reach the array index are kept; the upper
  // row bits can never be observed, so storing them would be dead state.
  // ------------------------------------------------------------------
  logic [MEM_ROW_BITS-1:0] row_reg [4];
  logic [12:0]             mode_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_open <= '0;
      ref_cnt  <= '0;
      mode_reg <= '0;
      for (int b = 0; b < 4; b++) begin
        row_reg[b] <= '0;
      end
    end else begin
      if (is_act) begin
        row_open[sdram_ba] <= 1'b1;
        row_reg[sdram_ba]  <= sdram_a[MEM_ROW_BITS-1:0];
      end
      // row_reg is deliberately left alone so a closed bank still maps
      // onto the last row it had open.
      if (is_pre) begin
        if (sdram_a[10]) begin
          row_open <= '0;
        end else begin
          row_open[sdram_ba] <= 1'b0;
        end
      end
      if (is_ref && (ref_cnt != 16'hFFFF)) begin
        ref_cnt <= ref_cnt + 16'd1;
      end
      if (is_lmr) begin
        mode_reg <= sdram_a;
      end
    end
  end

  // ------------------------------------------------------------------
  // Word array. Not reset, so data survives a reset pulse.
  // ------------------------------------------------------------------
  logic [31:0]         mem [DEPTH];
  logic [IDX_BITS-1:0] idx;
  logic [31:0]         rd_data;

  assign idx     = {sdram_ba, row_reg[sdram_ba], sdram_a[9:2]};
  assign rd_data = mem[idx];

  always_ff @(posedge clk) begin
    if (!rst && is_wr && !sdram_dqm) begin
      mem[idx] <= dq_in;
    end
  end

  // ------------------------------------------------------------------
  // Read pipe. The array is read at the sampling edge; dq_out itself is
  // the last stage, so CAS_LAT-1 registers sit in front of it and with
  // CAS_LAT = 1 the array output goes straight into dq_out.
  // ------------------------------------------------------------------
  logic        exit_vld;
  logic [31:0] exit_dat;

  generate
    if (CAS_LAT == 1) begin : g_direct
      assign exit_vld = is_rd;
      assign exit_dat = rd_data;
    end else begin : g_pipe
      logic [CAS_LAT-2:0] vld_q;
      logic [31:0]        dat_q [CAS_LAT-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= is_rd;
          for (int i = 1; i < CAS_LAT - 1; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        dat_q[0] <= rd_data;
        for (int i = 1; i < CAS_LAT - 1; i++) begin
          dat_q[i] <= dat_q[i-1];
        end
      end

      assign exit_vld = vld_q[CAS_LAT-2];
      assign exit_dat = dat_q[CAS_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      dq_out <= '0;
    end else if (exit_vld) begin
      dq_out <= exit_dat;
    end
  end

  // ------------------------------------------------------------------
  // Protocol checker.
  // Counters hold the distance in cycles from the last ACTIVE/PRECHARGE
  // of each bank: they load 1 at that command's edge so that a command
  // issued d cycles later sees the value d. They saturate at 7, which is
  // also the reset value so the first ACTIVE after reset is legal.
  // ------------------------------------------------------------------
`ifdef SDRAM_MODEL_CHECK_EN
  localparam logic [2:0] RCD_MIN = 3'(T_RCD);
  localparam logic [2:0] RP_MIN  = 3'(T_RP);

  logic [2:0] since_act [4];
  logic [2:0] since_pre [4];
  logic       viol;

  always_comb begin
    viol = 1'b0;
    if ((is_rd || is_wr) &&
        (!row_open[sdram_ba] || (since_act[sdram_ba] < RCD_MIN))) begin
      viol = 1'b1;
    end
    if (is_act &&
        (row_open[sdram_ba] || (since_pre[sdram_ba] < RP_MIN))) begin
      viol = 1'b1;
    end
    if (is_ref && (|row_open)) begin
      viol = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        since_act[b] <= 3'd7;
        since_pre[b] <= 3'd7;
      end
    end else begin
      if (viol) begin
        err <= 1'b1;
      end
      for (int b = 0; b < 4; b++) begin
        if (is_act && (sdram_ba == 2'(b))) begin
          since_act[b] <= 3'd1;
        end else if (since_act[b] != 3'd7) begin
          since_act[b] <= since_act[b] + 3'd1;
        end
        if (is_pre && (sdram_a[10] || (sdram_ba == 2'(b)))) begin
          since_pre[b] <= 3'd1;
        end else if (since_pre[b] != 3'd7) begin
          since_pre[b] <= since_pre[b] + 3'd1;
        end
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
